// File: rtl/lfsr_descramble.sv
// ---------------------------------------------------------------------------
// lfsr_descramble
//
// Self-synchronizing (multiplicative) descrambler, one DATA_WIDTH word per
// clock. The shift register s holds the most recently received scrambled
// bits, with s[k] being the bit received k+1 bit-times ago. Each received bit b
// is descrambled as
//   o = b ^ s[LFSR_WIDTH-1] ^ (XOR of s[j-1] for every tap j in LFSR_POLY[W-1:1])
// and then b (not o) is shifted into s[0]. All bits of a word are handled in
// time order within a single cycle by unrolling the serial recurrence.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous reset, active low
//   data_in       : scrambled word (DATA_WIDTH bits)
//   data_in_valid : qualifies data_in; when low, state and output hold
//   data_out      : descrambled word, registered (one cycle latency)
// ---------------------------------------------------------------------------
module lfsr_descramble #(
    parameter int                    LFSR_WIDTH  = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 58'h8000000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
    parameter                        LFSR_CONFIG = "FIBONACCI",
    parameter int                    REVERSE     = 1,
    parameter int                    DATA_WIDTH  = 64,
    parameter                        STYLE       = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Taps below the top term: mask bit k selects s[k] for polynomial term j=k+1.
    // The x^0 term (LFSR_POLY[0]) does not reference register state.
    localparam logic [LFSR_WIDTH-2:0] TAP_MASK = LFSR_POLY[LFSR_WIDTH-1:1];

    generate
        if (LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
            $error("lfsr_descramble: only FIBONACCI configuration is supported");
        end
        if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
            $error("lfsr_descramble: STYLE must be AUTO, LOOP or REDUCTION");
        end
    endgenerate

    logic [LFSR_WIDTH-1:0] s;
    logic [LFSR_WIDTH-1:0] s_walk;
    logic [LFSR_WIDTH-1:0] s_next;
    logic [DATA_WIDTH-1:0] data_next;

    // Position within the word of the n-th bit in time.
    function automatic int bit_pos(input int n);
        if (REVERSE != 0) begin
            return n;
        end
        return DATA_WIDTH - 1 - n;
    endfunction

    // Descrambling mask bit produced by the current register contents.
    function automatic logic feedback(input logic [LFSR_WIDTH-1:0] state);
        return state[LFSR_WIDTH-1] ^ (^(state[LFSR_WIDTH-2:0] & TAP_MASK));
    endfunction

    // Unrolled serial recurrence: every bit sees the register as updated by
    // all earlier bits of the same word.
    always_comb begin
        s_walk    = s;
        data_next = '0;
        for (int n = 0; n < DATA_WIDTH; n++) begin
            data_next[bit_pos(n)] = data_in[bit_pos(n)] ^ feedback(s_walk);
            s_walk                = {s_walk[LFSR_WIDTH-2:0], data_in[bit_pos(n)]};
        end
        s_next = s_walk;
    end

    // ---- register stage: state and output word ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            s        <= LFSR_INIT;
            data_out <= '0;
        end else if (data_in_valid) begin
            s        <= s_next;
            data_out <= data_next;
        end
    end

endmodule

// File: tb/tb_lfsr_descramble.sv
module tb_lfsr_descramble;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [63:0] data_out;

    always #5 clk = ~clk;

    lfsr_descramble dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_out(data_out)
    );

    // Parameter sweep instances share one random bus and valid.
    logic [65:0] sw_din = '0;
    logic        sw_vld = 1'b0;
    logic [7:0]  o8_m, o8_l;
    logic [31:0] o32_m, o32_l;
    logic [65:0] o66_m, o66_l;

    lfsr_descramble #(.DATA_WIDTH(8),  .REVERSE(0)) u_w8_m  (.clk(clk), .rst(rst), .data_in(sw_din[7:0]),  .data_in_valid(sw_vld), .data_out(o8_m));
    lfsr_descramble #(.DATA_WIDTH(8),  .REVERSE(1)) u_w8_l  (.clk(clk), .rst(rst), .data_in(sw_din[7:0]),  .data_in_valid(sw_vld), .data_out(o8_l));
    lfsr_descramble #(.DATA_WIDTH(32), .REVERSE(0)) u_w32_m (.clk(clk), .rst(rst), .data_in(sw_din[31:0]), .data_in_valid(sw_vld), .data_out(o32_m));
    lfsr_descramble #(.DATA_WIDTH(32), .REVERSE(1)) u_w32_l (.clk(clk), .rst(rst), .data_in(sw_din[31:0]), .data_in_valid(sw_vld), .data_out(o32_l));
    lfsr_descramble #(.DATA_WIDTH(66), .REVERSE(0)) u_w66_m (.clk(clk), .rst(rst), .data_in(sw_din),       .data_in_valid(sw_vld), .data_out(o66_m));
    lfsr_descramble #(.DATA_WIDTH(66), .REVERSE(1)) u_w66_l (.clk(clk), .rst(rst), .data_in(sw_din),       .data_in_valid(sw_vld), .data_out(o66_l));

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard for the default instance.
    logic [63:0] exp_q[$];
    bit          chk_q[$];
    string       tag_q[$];

    logic [57:0] rx_st;      // reference receiver register
    logic [57:0] tx_st;      // scrambler register
    logic [63:0] model_out;  // expected data_out of the default instance

    logic [57:0] sw_st [6];
    logic [65:0] sw_exp[6];
    int          sw_w  [6] = '{8, 8, 32, 32, 66, 66};
    bit          sw_r  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Bit-serial reference for x^58+x^39+1.
    function automatic void ref_desc(input logic [57:0] st_in, input logic [65:0] w,
                                     input int width, input bit rev,
                                     output logic [57:0] st_out, output logic [65:0] o);
        logic [57:0] st;
        int          idx;
        logic        b;
        st = st_in;
        o  = '0;
        for (int n = 0; n < width; n++) begin
            idx    = rev ? n : width - 1 - n;
            b      = w[idx];
            o[idx] = b ^ st[57] ^ st[38];
            st     = {st[56:0], b};
        end
        st_out = st;
    endfunction

    // Matching LSB-first multiplicative scrambler.
    function automatic logic [63:0] scramble(input logic [63:0] p);
        logic [63:0] c;
        for (int n = 0; n < 64; n++) begin
            c[n]  = p[n] ^ tx_st[57] ^ tx_st[38];
            tx_st = {tx_st[56:0], c[n]};
        end
        return c;
    endfunction

    function automatic logic [65:0] sw_out(input int k);
        case (k)
            0:       return {58'd0, o8_m};
            1:       return {58'd0, o8_l};
            2:       return {34'd0, o32_m};
            3:       return {34'd0, o32_l};
            4:       return o66_m;
            default: return o66_l;
        endcase
    endfunction

    task automatic step(input logic rst_v, input logic vld, input logic [63:0] d,
                        input logic [63:0] exp_v, input string tag);
        logic [63:0] e;
        bit          c;
        string       t;
        rst = rst_v;
        data_in_valid = vld;
        data_in = d;
        exp_q.push_back(exp_v);
        chk_q.push_back(1'b1);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        t = tag_q.pop_front();
        if (c) begin
            n_assert++;
            assert (data_out === e)
            else begin
                n_fail++;
                $error("FAIL %s: data_out=%h expected %h", t, data_out, e);
            end
        end
    endtask

    // Drive one reference-model word into the default instance.
    task automatic rx_word(input logic [63:0] d, input string tag);
        logic [65:0] o;
        ref_desc(rx_st, {2'b00, d}, 64, 1'b1, rx_st, o);
        model_out = o[63:0];
        step(1'b1, 1'b1, d, model_out, tag);
    endtask

    // Round-trip word: expected output is the plaintext itself.
    task automatic rt_word(input logic [63:0] p, input string tag);
        logic [63:0] c;
        logic [65:0] o;
        c = scramble(p);
        ref_desc(rx_st, {2'b00, c}, 64, 1'b1, rx_st, o);
        model_out = p;
        step(1'b1, 1'b1, c, p, tag);
    endtask

    task automatic gap(input string tag);
        step(1'b1, 1'b0, {$urandom, $urandom}, model_out, tag);
    endtask

    task automatic do_reset(input string tag);
        rx_st = '1;
        model_out = '0;
        step(1'b0, 1'b1, {$urandom, $urandom}, 64'd0, tag);
    endtask

    task automatic sw_step(input logic rst_v, input logic vld);
        logic [65:0] w;
        w = {$urandom, $urandom, $urandom};
        rst = rst_v;
        sw_vld = vld;
        sw_din = w;
        for (int k = 0; k < 6; k++) begin
            if (!rst_v) begin
                sw_st[k]  = '1;
                sw_exp[k] = '0;
            end else if (vld) begin
                ref_desc(sw_st[k], w, sw_w[k], sw_r[k], sw_st[k], sw_exp[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            n_assert++;
            assert (sw_out(k) === sw_exp[k])
            else begin
                n_fail++;
                $error("FAIL sweep_w%0d_rev%0d: data_out=%h expected %h",
                       sw_w[k], sw_r[k], sw_out(k), sw_exp[k]);
            end
        end
    endtask

    initial begin
        logic [63:0] p;
        rx_st = '1;
        model_out = '0;
        tx_st = {$urandom, $urandom};

        // Reset held for two cycles.
        step(1'b0, 1'b0, 64'd0, 64'd0, "reset_c1");
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "reset_c2");

        // Fresh descramble of zeros from the all-ones state.
        rx_st = '1;
        step(1'b1, 1'b1, 64'd0, 64'h03FF_FF80_0000_0000, "fresh_word1");
        step(1'b1, 1'b1, 64'd0, 64'd0, "fresh_word2");
        rx_st = '0;
        model_out = '0;
        gap("fresh_hold");

        // Round trip: first word checked against the reference, then plaintext.
        rx_word(scramble({$urandom, $urandom}), "rt_first");
        for (int i = 0; i < 12; i++) begin
            p = {$urandom, $urandom};
            rt_word(p, "rt_plain");
        end
        rt_word(64'd0, "rt_zero");
        rt_word(64'hFFFF_FFFF_FFFF_FFFF, "rt_ones");

        // Valid gating with random gaps.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                gap("gate_hold");
            end else begin
                p = {$urandom, $urandom};
                rt_word(p, "gate_plain");
            end
        end

        // Mid-stream reset, then resynchronization after one valid word.
        do_reset("mid_reset");
        rx_word(scramble({$urandom, $urandom}), "resync_first");
        for (int i = 0; i < 6; i++) begin
            p = {$urandom, $urandom};
            rt_word(p, "resync_plain");
        end

        // Parameter sweep against the bit-serial reference.
        sw_step(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            sw_step(1'b1, ($urandom_range(0, 3) != 0));
        end
        sw_step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sw_step(1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_descramble.md
LFSR_DESCRAMBLE -- requirements
Module: lfsr_descramble

Interface
REQ-001 The block SHALL have parameter LFSR_WIDTH, default 58: length of the descrambler shift register, in bits.
REQ-002 The block SHALL have parameter LFSR_POLY, default 58'h8000000001: feedback polynomial with the x^LFSR_WIDTH term implicit; bit j set means the x^j term is present (default is x^58+x^39+1).
REQ-003 The block SHALL have parameter LFSR_INIT, default all ones (LFSR_WIDTH bits): shift-register reset value.
REQ-004 The block SHALL have parameter LFSR_CONFIG, default "FIBONACCI": only "FIBONACCI" is supported; any other value SHALL be an elaboration error.
REQ-005 The block SHALL have parameter REVERSE, default 1: 1 = data_in bit 0 is the first bit in time (LSB first); 0 = bit DATA_WIDTH-1 is first (MSB first).
REQ-006 The block SHALL have parameter DATA_WIDTH, default 64: word width, any value >= 1, including values smaller or larger than LFSR_WIDTH.
REQ-007 The block SHALL have parameter STYLE, default "AUTO": implementation hint ("AUTO", "LOOP" or "REDUCTION"), with no effect on function.
REQ-008 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-009 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-010 The block SHALL have port data_in, input, DATA_WIDTH bits: scrambled word.
REQ-011 The block SHALL have port data_in_valid, input, 1 bit: data_in qualifier.
REQ-012 The block SHALL have port data_out, output, DATA_WIDTH bits: descrambled word, registered.

Function
REQ-013 The block SHALL implement a self-synchronizing (multiplicative) descrambler: register s[LFSR_WIDTH-1:0] holds the most recently received scrambled bits, with s[k] being the bit received k+1 bit-times ago.
REQ-014 For each input bit b in time order, the output bit SHALL be o = b XOR s[LFSR_WIDTH-1] XOR (XOR of s[j-1] over every j in 1..LFSR_WIDTH-1 with LFSR_POLY[j]=1).
REQ-015 After each bit, s SHALL shift up by one, with s[0] taking the received scrambled bit b (not o).
REQ-016 All DATA_WIDTH bits of a word SHALL be processed serially within one cycle in the order set by REVERSE (combinational unrolling), and each bit SHALL see the s value updated by all earlier bits of the same word.
REQ-017 On a rising clk edge with rst high and data_in_valid=1, data_out SHALL load the descrambled word and s SHALL load its post-word value; latency is one cycle.
REQ-018 On a rising clk edge with rst high and data_in_valid=0, data_out and s SHALL hold their values.
REQ-019 data_out SHALL be a pure register output with no combinational path from data_in.
REQ-020 Descrambling SHALL depend only on the last LFSR_WIDTH received bits, so the output SHALL self-synchronize with the transmitter after LFSR_WIDTH valid bits regardless of s.

Reset
REQ-021 On a rising clk edge with rst=0, s SHALL be set to LFSR_INIT and data_out to 0, regardless of data_in_valid.
REQ-022 Reset SHALL take priority at any time, including mid-stream; the first valid word after reset SHALL use s=LFSR_INIT.

Verification
REQ-023 Reset check, defaults: hold rst=0 for 2 cycles -> data_out=0.
REQ-024 Fresh descramble, defaults: after reset, apply data_in=0 with valid=1 -> data_out=64'h03FFFF8000000000 (bits 39..57 set); then a second data_in=0 with valid -> data_out=0.
REQ-025 Round trip: scramble random 64-bit words with the matching x^58+x^39+1 LSB-first scrambler from an arbitrary seed and feed them with valid=1 -> from the second word onward, data_out equals the original plaintext one cycle later.
REQ-026 Valid gating: insert random valid=0 cycles into the round-trip stream -> data_out holds during the gaps and the plaintext sequence is unbroken.
REQ-027 Mid-stream reset: assert rst=0 for one cycle during the round-trip stream -> data_out=0 next cycle, and the output resynchronizes after one full valid word.
REQ-028 Parameter sweep: DATA_WIDTH in {8, 32, 66} and REVERSE in {0, 1}, each against a bit-serial reference model -> every output bit matches.
